// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC sequencer with redirect buffering and post-redirect flush
// Optional macro BRANCH_STATS_EN adds the taken_count output (accepted taken-branch counter).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_2000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        redirect_pending
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] taken_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        live_q, live_d;

    logic        hold;
    logic        redirect;
    logic [31:0] target_al;
    logic [31:0] pc_inc;

    always_comb begin
        hold      = stall | ~imem_ready;
        redirect  = br_taken | jump;
        // Branch resolves in EX, so it is older than a jump in ID and wins.
        target_al = (br_taken ? br_target : jump_target) & 32'hFFFF_FFFC;
        pc_inc    = pc_q + 32'd4;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_tgt_d  = pend_tgt_q;
        flush_cnt_d = flush_cnt_q;
        live_d      = 1'b1;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if (hold) begin
                        pend_tgt_d = target_al;
                        state_d    = ST_PEND;
                    end else begin
                        pc_d        = target_al;
                        flush_cnt_d = FLUSH_INIT;
                        state_d     = ST_FLUSH;
                    end
                end else if (!hold && live_q) begin
                    // The first cycle after reset presents RESET_PC without fetching it.
                    pc_d = pc_inc;
                end
            end
            ST_PEND: begin
                if (!hold) begin
                    pc_d        = pend_tgt_q;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!hold) begin
                    pc_d = pc_inc;
                end
                if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            pend_tgt_q  <= 32'd0;
            flush_cnt_q <= 3'd0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_tgt_q  <= pend_tgt_d;
            flush_cnt_q <= flush_cnt_d;
            live_q      <= live_d;
        end
    end

    assign pc               = pc_q;
    assign pc_valid         = live_q & (state_q != ST_FLUSH);
    assign flush            = (state_q == ST_FLUSH);
    assign redirect_pending = (state_q == ST_PEND);

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_q, taken_d;

    // Counted when the branch is accepted in RUN, so a buffered branch counts once.
    always_comb begin
        taken_d = taken_q;
        if (state_q == ST_RUN && br_taken && taken_q != 32'hFFFF_FFFF) begin
            taken_d = taken_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= 32'd0;
        end else begin
            taken_q <= taken_d;
        end
    end

    assign taken_count = taken_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_2000;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, imem_ready, br_taken, jump;
    logic [31:0] br_target, jump_target;
    logic [31:0] pc;
    logic        pc_valid, flush, redirect_pending;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count;
`endif

    fetch_pc_unit #(
        .RESET_PC    (RESET_PC),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .imem_ready      (imem_ready),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .flush           (flush),
        .redirect_pending(redirect_pending)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count     (taken_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        rp;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    // Reference model: a fetch address, a buffered redirect, and a number of flush cycles left.
    logic [31:0] m_pc, m_pend, m_cnt;
    bit          m_pending, m_live;
    int          m_flush_left;

    function automatic exp_t model_view();
        exp_t e;
        e.pc    = m_pc;
        e.valid = m_live && (m_flush_left == 0);
        e.flush = (m_flush_left > 0);
        e.rp    = m_pending;
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_pend = 32'd0; m_cnt = 32'd0;
        m_pending = 1'b0; m_live = 1'b0; m_flush_left = 0;
    endtask

    task automatic model_edge(input bit st, input bit rdy, input bit bt, input logic [31:0] btg,
                              input bit j, input logic [31:0] jt);
        bit          hold;
        logic [31:0] t;
        hold = st || !rdy;
        if (m_flush_left > 0) begin
            if (!hold) m_pc = m_pc + 32'd4;
            m_flush_left = m_flush_left - 1;
        end else if (m_pending) begin
            if (!hold) begin
                m_pc = m_pend; m_pending = 1'b0; m_flush_left = FLUSH_CYCLES;
            end
        end else if (bt || j) begin
            t = (bt ? btg : jt) & 32'hFFFF_FFFC;
            if (bt && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (hold) begin
                m_pending = 1'b1; m_pend = t;
            end else begin
                m_pc = t; m_flush_left = FLUSH_CYCLES;
            end
        end else if (!hold && m_live) begin
            m_pc = m_pc + 32'd4;
        end
        m_live = 1'b1;
    endtask

    task automatic step(input bit st, input bit rdy, input bit bt, input logic [31:0] btg,
                        input bit j, input logic [31:0] jt);
        stall = st; imem_ready = rdy; br_taken = bt; br_target = btg;
        jump = j; jump_target = jt;
        model_edge(st, rdy, bt, btg, j, jt);
        exp_q.push_back(model_view());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(3) == 0, $urandom_range(7) != 0, $urandom_range(9) == 0, $urandom,
                 $urandom_range(9) == 0, $urandom);
        end
    endtask

    // Reset asserted between clock edges; held across one rising edge and released on a falling edge.
    task automatic reset_mid();
        #2;
        model_reset();
        exp_q.push_back(model_view());
        exp_q.push_back(model_view());
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (mon_en) begin
            exp_t e;
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty at %0t: DUT output with no expectation", $time);
            end else begin
                e = exp_q.pop_front();
                if (pc !== e.pc || pc_valid !== e.valid || flush !== e.flush ||
                    redirect_pending !== e.rp) begin
                    n_err++;
                    $display("FAIL outputs at %0t: got pc=%h valid=%b flush=%b pend=%b, expected pc=%h valid=%b flush=%b pend=%b",
                             $time, pc, pc_valid, flush, redirect_pending, e.pc, e.valid, e.flush, e.rp);
                end
`ifdef BRANCH_STATS_EN
                n_vec++;
                if (taken_count !== e.cnt) begin
                    n_err++;
                    $display("FAIL taken_count at %0t: got %h expected %h", $time, taken_count, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; imem_ready = 1'b1; br_taken = 1'b0; br_target = 32'd0;
        jump = 1'b0; jump_target = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        exp_q.push_back(model_view());
        @(negedge clk);
        rst_n = 1'b1;

        // Boot sequence: 2000 (not valid), 2000, 2004, 2008
        idle(4);
        // Immediate branch with misaligned target
        step(1'b0, 1'b1, 1'b1, 32'h0000_3003, 1'b0, 32'd0);
        idle(4);
        // Buffered branch under stall, later jump ignored
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_5000);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(5);
        // Simultaneous branch and jump
        step(1'b0, 1'b1, 1'b1, 32'h0000_6000, 1'b1, 32'h0000_7000);
        idle(4);
        // Wrap: jump lands at FFFF_FFF0, flush advances to FFFF_FFF8, then FFFC, 0000_0000
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFF0);
        idle(5);
        // Redirect during flush ignored; flush counts down under hold
        step(1'b0, 1'b1, 1'b1, 32'h0000_8000, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_A000, 1'b1, 32'h0000_B000);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(3);
        rand_steps(400);
        // Reset in the middle of PEND
        idle(2);
        step(1'b1, 1'b1, 1'b1, 32'h0000_9000, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        reset_mid();
        idle(5);
        rand_steps(300);
        // Reset in the middle of FLUSH
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_C000);
        reset_mid();
        idle(4);
        rand_steps(100);

        mon_en = 1'b0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_2000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1-7, meaning the number of flush cycles after each redirect.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  pipeline hold request from downstream.
REQ-006 SHALL have port imem_ready  input  1  instruction memory can accept an address this cycle.
REQ-007 SHALL have port br_taken  input  1  resolved conditional-branch-taken flag from the branch comparator in EX.
REQ-008 SHALL have port br_target  input  32  branch target address.
REQ-009 SHALL have port jump  input  1  unconditional JAL/JALR redirect from ID.
REQ-010 SHALL have port jump_target  input  32  jump target address.
REQ-011 SHALL have port pc  output  32  current fetch address.
REQ-012 SHALL have port pc_valid  output  1  pc is a live fetch request.
REQ-013 SHALL have port flush  output  1  kill the instructions in IF/ID.
REQ-014 SHALL have port redirect_pending  output  1  a redirect is buffered awaiting release of hold.

Function
REQ-015 SHALL define hold = stall OR NOT imem_ready.
REQ-016 SHALL define redirect = br_taken OR jump; when both are high, br_taken SHALL win (older instruction).
REQ-017 SHALL force bits [1:0] of any accepted target to 2'b00.
REQ-018 SHALL implement three states: RUN, PEND, FLUSH.
REQ-019 In RUN with no redirect and no hold, pc SHALL advance by 4 each cycle, with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 In RUN with hold and no redirect, pc SHALL hold its value.
REQ-021 In RUN with redirect and no hold, pc SHALL load the target on the next edge and the state SHALL go to FLUSH; this is a one-cycle redirect latency.
REQ-022 In RUN with redirect and hold, the target SHALL be latched into a pending register, pc SHALL hold, and the state SHALL go to PEND.
REQ-023 In PEND, redirect_pending SHALL be 1; further redirects SHALL be ignored because they come from the wrong path; pc SHALL hold.
REQ-024 In PEND, on the first cycle with hold low, pc SHALL load the pending target, redirect_pending SHALL clear next edge, and the state SHALL go to FLUSH.
REQ-025 FLUSH SHALL last exactly FLUSH_CYCLES cycles with flush=1, then return to RUN.
REQ-026 In FLUSH, pc SHALL advance by 4 per cycle when hold is low and hold otherwise; the flush count SHALL decrement every cycle regardless of hold.
REQ-027 Redirects arriving in FLUSH SHALL be ignored.
REQ-028 flush SHALL be 0 in RUN and PEND.
REQ-029 pc_valid SHALL be 0 in the first cycle after reset deassertion and 1 thereafter, except 0 during FLUSH.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately force the following, regardless of the clock: pc=RESET_PC, pc_valid=0, flush=0, redirect_pending=0, state=RUN, pending target=0, flush count=0.
REQ-031 Reset asserted mid-PEND or mid-FLUSH SHALL discard the buffered redirect and the remaining flush cycles.

Configuration
REQ-032 With macro BRANCH_STATS_EN defined, the block SHALL add output taken_count (32 bits, reset 0).
REQ-033 taken_count SHALL increment once per accepted br_taken redirect, whether immediate or buffered, and SHALL saturate at 32'hFFFF_FFFF; accepted jumps and ignored redirects SHALL not count.
REQ-034 Without BRANCH_STATS_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Release reset with hold=0 and no redirects -> pc sequence 0x2000, 0x2000 (pc_valid=0), 0x2004, 0x2008; pc_valid=1 from the second cycle.
REQ-036 In RUN, pulse br_taken=1 with br_target=0x3003 -> next cycle pc=0x3000, flush=1 for 2 cycles, pc_valid=0, then pc=0x3008 and state RUN.
REQ-037 stall=1, then br_taken with target 0x4000, then jump with target 0x5000, then stall=0 three cycles later -> redirect_pending=1 throughout the stall; pc=0x4000 the cycle after stall falls; 0x5000 is never fetched.
REQ-038 Assert br_taken (target 0x6000) and jump (target 0x7000) in the same cycle -> pc=0x6000; with BRANCH_STATS_EN, taken_count increments by 1.
REQ-039 Start pc at 0xFFFF_FFF8 with no hold -> pc goes 0xFFFF_FFFC, then 0x0000_0000.
REQ-040 Assert rst_n=0 mid-PEND between clock edges -> pc=0x2000, redirect_pending=0, flush=0 immediately; after release the buffered target is never applied.
